// File: rtl/max7219_frame_tx.sv
// rtl/max7219_frame_tx.sv - MAX7219 16-bit frame serializer (cs/sclk/mosi), transmit only
module max7219_frame_tx #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        mosi,
    output logic        sclk,
    output logic        cs,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} state_t;

    localparam int MAX_LEN = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int DW      = $clog2(MAX_LEN) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(CS_GAP - 1);

    state_t         state, state_n;
    logic [DW-1:0]  div_cnt, div_n;
    logic [3:0]     bit_cnt, bit_n;
    logic [15:0]    sreg, sreg_n;
    logic           cs_q, cs_n;
    logic           sclk_q, sclk_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic           div_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            sreg    <= sreg_n;
            cs_q    <= cs_n;
            sclk_q  <= sclk_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // div_cnt counts cycles spent in the current state; every exit resets it.
    always_comb begin
        state_n = state;
        div_n   = div_cnt + DW'(1);
        bit_n   = bit_cnt;
        sreg_n  = sreg;
        cs_n    = cs_q;
        sclk_n  = sclk_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        div_end = (div_cnt == DIV_LAST);
        case (state)
            IDLE: begin
                div_n = '0;
                if (tx_valid) begin
                    state_n = SETUP;
                    sreg_n  = tx_data;
                    bit_n   = 4'd15;
                    busy_n  = 1'b1;
                    cs_n    = 1'b0;
                    sclk_n  = 1'b0;
                end
            end
            SETUP, LOW: begin
                if (div_end) begin
                    state_n = HIGH;
                    div_n   = '0;
                    sclk_n  = 1'b1;
                end
            end
            HIGH: begin
                if (div_end) begin
                    div_n  = '0;
                    sclk_n = 1'b0;
                    if (bit_cnt == 4'd0) begin
                        state_n = TAIL;
                    end else begin
                        state_n = LOW;
                        sreg_n  = {sreg[14:0], 1'b0};
                        bit_n   = bit_cnt - 4'd1;
                    end
                end
            end
            TAIL: begin
                if (div_end) begin
                    state_n = GAP;
                    div_n   = '0;
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    sreg_n  = '0;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    state_n = IDLE;
                    div_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // mosi is the flop output of the shift register MSB, so it is glitch-free.
    assign tx_ready = (state == IDLE);
    assign mosi     = sreg[15];
    assign sclk     = sclk_q;
    assign cs       = cs_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
